switch_debouncer: RTL and testbench

//  Conditions raw Basys3 slide-switch / push-button inputs before they reach the

---
 rtl/switch_debouncer.sv | 186 ++++++++++++++++++
 tb/tb_switch_debouncer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Conditions raw slide-switch / push-button inputs before they feed gate
//   exercise logic. Each channel has its own 2-flop synchroniser, a
//   stability-counter debounce FSM, a registered clean level and one-cycle
//   rise/fall pulses. Channels share nothing but the clock and reset.
//
//   Optional feature: define SWITCH_DEBOUNCER_TOGGLE_EN to add toggle_out,
//   a per-channel flop that inverts on every accepted rising edge so a
//   push button can act as a latched input. Without the macro the port and
//   its flops do not exist.
//
// Parameters
//   N_CH           number of independent channels
//   STABLE_CYCLES  cycles the synchronised input must hold before a new level
//                  is accepted (>= 1)
//   CNT_W          stability counter width, 2**CNT_W >= STABLE_CYCLES
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active low
//   raw_in      asynchronous switch/button inputs
//   level_out   debounced level, registered
//   rise_out    one-cycle pulse on an accepted 0->1 transition
//   fall_out    one-cycle pulse on an accepted 1->0 transition
//   toggle_out  (SWITCH_DEBOUNCER_TOGGLE_EN only) flips after each rise_out
//
// Debounce FSM, one instance per channel:
//   state     | meaning
//   S_LOW     | accepted level 0, input agrees
//   S_WAIT_HI | accepted level 0, input seen high, counting stable cycles
//   S_HIGH    | accepted level 1, input agrees
//   S_WAIT_LO | accepted level 1, input seen low, counting stable cycles

module switch_debouncer #(
  parameter int N_CH          = 2,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  ,
  output logic [N_CH-1:0] toggle_out
`endif
);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  // Terminal count: the input has been stable for STABLE_CYCLES samples in
  // the wait state once the counter reaches this value. Comparing here
  // instead of at STABLE_CYCLES keeps the counter from ever needing to wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             in_s;

    assign in_s = sync2[i];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= S_LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      case (state_q)
        S_LOW: begin
          if (in_s) begin
            state_d = S_WAIT_HI;
            cnt_d   = '0;
          end
        end

        S_WAIT_HI: begin
          if (!in_s) begin
            // Bounce: drop back without touching the level or pulsing.
            state_d = S_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_HIGH: begin
          if (!in_s) begin
            state_d = S_WAIT_LO;
            cnt_d   = '0;
          end
        end

        S_WAIT_LO: begin
          if (in_s) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = S_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign level_out[i] = level_q;
    assign rise_out[i]  = rise_q;
    assign fall_out[i]  = fall_q;

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    logic toggle_q;

    // Flips on the cycle after the rise pulse is visible.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        toggle_q <= 1'b0;
      end else if (rise_q) begin
        toggle_q <= ~toggle_q;
      end
    end

    assign toggle_out[i] = toggle_q;
`endif
  end

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int N_CH = 2;
  localparam int SC   = 4;
  localparam int LAT  = SC + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] rise_out;
  logic [N_CH-1:0] fall_out;
  logic [N_CH-1:0] toggle_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw samples delayed by two clocks, then a level is
  // accepted once SC+1 consecutive delayed samples disagree with it.
  logic [N_CH-1:0] m_d0, m_d1, m_level, m_rise, m_fall, m_tog;
  int              m_run [N_CH];

  always #5 clk = ~clk;

  switch_debouncer #(
    .N_CH(N_CH),
    .STABLE_CYCLES(SC),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .raw_in(raw_in),
    .level_out(level_out),
    .rise_out(rise_out),
    .fall_out(fall_out)
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    ,
    .toggle_out(toggle_out)
`endif
  );

`ifndef SWITCH_DEBOUNCER_TOGGLE_EN
  assign toggle_out = '0;
`endif

  task automatic tick();
    logic s;
    @(posedge clk);
    for (int c = 0; c < N_CH; c++) begin
      if (!rst_n) begin
        m_d0[c] = 1'b0; m_d1[c] = 1'b0; m_level[c] = 1'b0;
        m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_tog[c] = 1'b0; m_run[c] = 0;
      end else begin
        m_tog[c] = m_tog[c] ^ m_rise[c];
        s = m_d1[c];
        m_d1[c] = m_d0[c];
        m_d0[c] = raw_in[c];
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (s != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] >= SC + 1) begin
            m_level[c] = s;
            if (s) m_rise[c] = 1'b1;
            else   m_fall[c] = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    raw_in = 2'b11;
    rst_n  = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if ({level_out, rise_out, fall_out, toggle_out} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got lvl=%b rise=%b fall=%b tog=%b, want all 0",
               level_out, rise_out, fall_out, toggle_out);
    end
    rst_n = 1'b1;
    // Edge 1 here is the release edge; acceptance lands LAT edges after it.
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      n_checks++;
      if (level_out !== ((k >= LAT + 1) ? 2'b11 : 2'b00) ||
          rise_out  !== ((k == LAT + 1) ? 2'b11 : 2'b00) ||
          fall_out  !== 2'b00 ||
          {level_out, rise_out, fall_out} !== {m_level, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL reset_release k=%0d: got lvl=%b rise=%b fall=%b, want lvl=%b rise=%b fall=%b",
                 k, level_out, rise_out, fall_out, m_level, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_clean_edge();
    raw_in = 2'b00;
    for (int k = 0; k < 12; k++) tick();
    n_checks++;
    if (level_out !== 2'b00) begin
      n_fail++;
      $display("FAIL clean_settle: got lvl=%b, want 00", level_out);
    end
    raw_in[0] = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      n_checks++;
      if (level_out[0] !== (k >= LAT + 1) || rise_out[0] !== (k == LAT + 1) ||
          fall_out[0] !== 1'b0 ||
          {level_out, rise_out, fall_out} !== {m_level, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL clean_rise k=%0d: got lvl=%b rise=%b fall=%b, want lvl0=%b rise0=%b",
                 k, level_out, rise_out, fall_out, k >= LAT + 1, k == LAT + 1);
      end
    end
    raw_in[0] = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      n_checks++;
      if (level_out[0] !== (k < LAT + 1) || fall_out[0] !== (k == LAT + 1) ||
          rise_out[0] !== 1'b0 ||
          {level_out, rise_out, fall_out} !== {m_level, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL clean_fall k=%0d: got lvl=%b rise=%b fall=%b, want lvl0=%b fall0=%b",
                 k, level_out, rise_out, fall_out, k < LAT + 1, k == LAT + 1);
      end
    end
  endtask

  task automatic test_bounce();
    raw_in = 2'b00;
    for (int k = 0; k < 8; k++) tick();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 5; k++) begin
        raw_in[1] = (k < 3);
        tick();
        n_checks++;
        if (level_out[1] !== 1'b0 || rise_out[1] !== 1'b0 || fall_out[1] !== 1'b0 ||
            {level_out, rise_out, fall_out} !== {m_level, m_rise, m_fall}) begin
          n_fail++;
          $display("FAIL bounce r=%0d k=%0d: got lvl=%b rise=%b fall=%b, want ch1 all 0",
                   r, k, level_out, rise_out, fall_out);
        end
      end
    end
    raw_in = 2'b00;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_reset_mid();
    raw_in = 2'b01;
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({level_out, rise_out, fall_out} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got lvl=%b rise=%b fall=%b, want all 0",
               level_out, rise_out, fall_out);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      n_checks++;
      if (level_out[0] !== (k >= LAT + 1) || rise_out[0] !== (k == LAT + 1) ||
          {level_out, rise_out, fall_out} !== {m_level, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d: got lvl=%b rise=%b, want lvl0=%b rise0=%b",
                 k, level_out, rise_out, k >= LAT + 1, k == LAT + 1);
      end
    end
  endtask

  task automatic test_independence();
    raw_in = 2'b10;
    for (int k = 0; k < 12; k++) tick();
    n_checks++;
    if (level_out !== 2'b10) begin
      n_fail++;
      $display("FAIL indep_setup: got lvl=%b, want 10", level_out);
    end
    raw_in = 2'b01;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      n_checks++;
      if (rise_out !== ((k == LAT + 1) ? 2'b01 : 2'b00) ||
          fall_out !== ((k == LAT + 1) ? 2'b10 : 2'b00) ||
          level_out !== ((k >= LAT + 1) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL indep k=%0d: got lvl=%b rise=%b fall=%b", k, level_out, rise_out, fall_out);
      end
    end
  endtask

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  task automatic test_toggle();
    logic exp_tog;
    raw_in = 2'b00;
    for (int k = 0; k < 12; k++) tick();
    exp_tog = toggle_out[0];
    for (int p = 0; p < 3; p++) begin
      raw_in[0] = 1'b1;
      for (int k = 1; k <= LAT + 3; k++) begin
        tick();
        if (k == LAT + 2) exp_tog = ~exp_tog;
        n_checks++;
        if (toggle_out[0] !== exp_tog || toggle_out !== m_tog) begin
          n_fail++;
          $display("FAIL toggle p=%0d k=%0d: got tog=%b, want tog0=%b model=%b",
                   p, k, toggle_out, exp_tog, m_tog);
        end
      end
      raw_in[0] = 1'b0;
      for (int k = 0; k < LAT + 3; k++) tick();
    end
  endtask
`endif

  task automatic test_random();
    int hold [N_CH];
    for (int c = 0; c < N_CH; c++) hold[c] = 0;
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (hold[c] == 0) begin
          raw_in[c] = 1'($urandom_range(0, 1));
          hold[c]   = (($urandom_range(0, 3) == 0) ? $urandom_range(6, 12)
                                                    : $urandom_range(1, 6));
        end
        hold[c]--;
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      n_checks++;
      if ({level_out, rise_out, fall_out, toggle_out} !==
          {m_level, m_rise, m_fall,
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
           m_tog
`else
           2'b00
`endif
          } || (rise_out & fall_out) !== 2'b00) begin
        n_fail++;
        $display("FAIL random k=%0d: got lvl=%b rise=%b fall=%b tog=%b, want lvl=%b rise=%b fall=%b",
                 k, level_out, rise_out, fall_out, toggle_out, m_level, m_rise, m_fall);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    raw_in = '0;
    m_d0 = '0; m_d1 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_tog = '0;
    for (int c = 0; c < N_CH; c++) m_run[c] = 0;
    @(negedge clk);
    test_reset();
    test_clean_edge();
    test_bounce();
    test_reset_mid();
    test_independence();
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    test_toggle();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
